// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the non-forwarding 5-stage pipeline: a per-register countdown
// scoreboard of in-flight writes drives the PC/IF-ID hold and the IF-ID / ID-EX bubbles.
module hazard_stall_ctrl #(
  parameter int PIPE_DEPTH = 3,
  parameter bit RF_BYPASS  = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_id_rd_addr,
  input  logic             i_id_rdwren,
  input  logic             i_br_taken_EX,
  output logic             o_pc_hold,
  output logic             o_if_id_hold,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int SB_RAW = $clog2(PIPE_DEPTH + 1);
  localparam int SB_W   = (SB_RAW < 2) ? 2 : SB_RAW;

  // A write-first regfile lets the reader overlap the producer's WB cycle.
  localparam logic [SB_W-1:0] TH   = RF_BYPASS ? SB_W'(2) : SB_W'(1);
  localparam logic [SB_W-1:0] LOAD = SB_W'(PIPE_DEPTH);

  logic [SB_W-1:0] cnt [32];
  logic haz1;
  logic haz2;
  logic stall;
  logic flush;
  logic issue;
  logic load_en;

  always_comb begin
    haz1    = i_id_valid & i_id_rs1_used & (i_id_rs1_addr != 5'd0) & (cnt[i_id_rs1_addr] >= TH);
    haz2    = i_id_valid & i_id_rs2_used & (i_id_rs2_addr != 5'd0) & (cnt[i_id_rs2_addr] >= TH);
    flush   = i_br_taken_EX;
    stall   = (haz1 | haz2) & ~flush;
    issue   = i_id_valid & ~stall & ~flush;
    load_en = issue & i_id_rdwren & (i_id_rd_addr != 5'd0);
  end

  assign o_pc_hold     = stall;
  assign o_if_id_hold  = stall;
  assign o_if_id_flush = flush;
  assign o_id_ex_flush = stall | flush;

  // Entry 0 is never loaded, so x0 always reads as free; a younger write reloads its counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (load_en && (i_id_rd_addr == 5'(r))) cnt[r] <= LOAD;
        else if (cnt[r] != '0)                 cnt[r] <= cnt[r] - SB_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (stall && (o_stall_cnt != {CNT_W{1'b1}})) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      if (flush && (o_flush_cnt != {CNT_W{1'b1}})) o_flush_cnt <= o_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: a write-first instance (a) and a no-bypass, 3-bit-counter instance (b)
// share stimulus and are checked against a ready-cycle model of the register scoreboard.
module tb_hazard_stall_ctrl;
  localparam int PD = 3;
  localparam int WA = 32;
  localparam int WB = 3;
  localparam longint MAX_A = (longint'(1) << WA) - 1;
  localparam longint MAX_B = (longint'(1) << WB) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, rs1_used, rs2_used, rdwren, br_taken;
  logic [4:0] rs1, rs2, rd;

  logic pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_flush_a;
  logic pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_flush_b;
  logic [WA-1:0] stall_cnt_a, flush_cnt_a;
  logic [WB-1:0] stall_cnt_b, flush_cnt_b;
  logic [3:0] ctrl_a, ctrl_b;

  assign ctrl_a = {pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_flush_a};
  assign ctrl_b = {pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_flush_b};

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.PIPE_DEPTH(PD), .RF_BYPASS(1'b1), .CNT_W(WA)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_id_rd_addr(rd), .i_id_rdwren(rdwren), .i_br_taken_EX(br_taken),
    .o_pc_hold(pc_hold_a), .o_if_id_hold(if_id_hold_a), .o_if_id_flush(if_id_flush_a),
    .o_id_ex_flush(id_ex_flush_a), .o_stall_cnt(stall_cnt_a), .o_flush_cnt(flush_cnt_a)
  );

  hazard_stall_ctrl #(.PIPE_DEPTH(PD), .RF_BYPASS(1'b0), .CNT_W(WB)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_id_rd_addr(rd), .i_id_rdwren(rdwren), .i_br_taken_EX(br_taken),
    .o_pc_hold(pc_hold_b), .o_if_id_hold(if_id_hold_b), .o_if_id_flush(if_id_flush_b),
    .o_id_ex_flush(id_ex_flush_b), .o_stall_cnt(stall_cnt_b), .o_flush_cnt(flush_cnt_b)
  );

  // Model: a register is readable from the cycle its write is far enough along (bypass reads in WB).
  int cyc;
  int rdy_a [32];
  int rdy_b [32];
  longint sc_a, fc_a, sc_b, fc_b;
  int n_cmp, n_bad;

  function automatic logic m_stall(input bit byp);
    int r1, r2;
    logic h1, h2;
    r1 = int'(rs1);
    r2 = int'(rs2);
    h1 = id_valid && rs1_used && (r1 != 0) && (cyc < (byp ? rdy_a[r1] : rdy_b[r1]));
    h2 = id_valid && rs2_used && (r2 != 0) && (cyc < (byp ? rdy_a[r2] : rdy_b[r2]));
    return (h1 || h2) && !br_taken;
  endfunction

  function automatic logic [3:0] exp_ctrl(input bit byp);
    logic s;
    s = m_stall(byp);
    return {s, s, br_taken, s | br_taken};
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      rdy_a[r] = 0;
      rdy_b[r] = 0;
    end
    sc_a = 0; fc_a = 0; sc_b = 0; fc_b = 0;
  endtask

  task automatic drive(input logic v, input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                       input logic u2, input logic [4:0] d, input logic w, input logic br);
    id_valid = v; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
    rd = d; rdwren = w; br_taken = br;
  endtask

  task automatic step();
    logic sa, sb, fl;
    sa = m_stall(1'b1);
    sb = m_stall(1'b0);
    fl = br_taken;
    @(posedge clk);
    if (id_valid && !sa && !fl && rdwren && rd != 5'd0) rdy_a[rd] = cyc + PD;
    if (id_valid && !sb && !fl && rdwren && rd != 5'd0) rdy_b[rd] = cyc + PD + 1;
    if (sa && sc_a < MAX_A) sc_a++;
    if (sb && sc_b < MAX_B) sc_b++;
    if (fl && fc_a < MAX_A) fc_a++;
    if (fl && fc_b < MAX_B) fc_b++;
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #3;
    n_cmp++;
    if ({ctrl_a, ctrl_b} !== 8'h00) begin
      n_bad++; $display("[TB] FAIL reset_ctrl got=%b want=00000000", {ctrl_a, ctrl_b});
    end
    n_cmp++;
    if (stall_cnt_a !== '0 || flush_cnt_a !== '0 || stall_cnt_b !== '0 || flush_cnt_b !== '0) begin
      n_bad++; $display("[TB] FAIL reset_cnt got=%0d/%0d/%0d/%0d want=0", stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b);
    end
    apply_reset();
  endtask

  task automatic test_independent();
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 1, 0, 0, 5'(i), 1, 0);
      @(negedge clk);
      n_cmp++;
      if (ctrl_a !== 4'b0000 || ctrl_b !== 4'b0000) begin
        n_bad++; $display("[TB] FAIL indep_ctrl i=%0d got=%b/%b want=0000", i, ctrl_a, ctrl_b);
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (stall_cnt_a !== '0 || stall_cnt_b !== '0) begin
      n_bad++; $display("[TB] FAIL indep_stall_cnt got=%0d/%0d want=0", stall_cnt_a, stall_cnt_b);
    end
  endtask

  task automatic test_raw();
    apply_reset();
    drive(1, 0, 1, 0, 0, 5, 1, 0);
    @(negedge clk);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5, 1, 5, 1, 6, 1, 0);
      @(negedge clk);
      n_cmp++;
      if (ctrl_a !== exp_ctrl(1'b1) || pc_hold_a !== logic'(i < 2)) begin
        n_bad++; $display("[TB] FAIL raw_ctrl_a i=%0d got=%b want=%b", i, ctrl_a, exp_ctrl(1'b1));
      end
      n_cmp++;
      if (ctrl_b !== exp_ctrl(1'b0) || pc_hold_b !== logic'(i < 3)) begin
        n_bad++; $display("[TB] FAIL raw_ctrl_b i=%0d got=%b want=%b", i, ctrl_b, exp_ctrl(1'b0));
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (stall_cnt_a !== WA'(2) || stall_cnt_b !== WB'(3)) begin
      n_bad++; $display("[TB] FAIL raw_stall_cnt got=%0d/%0d want=2/3", stall_cnt_a, stall_cnt_b);
    end
  endtask

  task automatic test_x0_unused();
    apply_reset();
    drive(1, 0, 1, 0, 0, 0, 1, 0);
    @(negedge clk);
    step();
    drive(1, 0, 1, 0, 1, 11, 1, 0);
    @(negedge clk);
    n_cmp++;
    if (pc_hold_a !== 1'b0 || pc_hold_b !== 1'b0) begin
      n_bad++; $display("[TB] FAIL x0_reader got=%b/%b want=0/0", pc_hold_a, pc_hold_b);
    end
    step();
    drive(1, 0, 1, 0, 0, 7, 1, 0);
    @(negedge clk);
    step();
    drive(1, 7, 0, 7, 0, 12, 1, 0);
    @(negedge clk);
    n_cmp++;
    if (pc_hold_a !== 1'b0 || pc_hold_b !== 1'b0) begin
      n_bad++; $display("[TB] FAIL unused_src got=%b/%b want=0/0", pc_hold_a, pc_hold_b);
    end
    step();
  endtask

  task automatic test_waw();
    apply_reset();
    drive(1, 0, 1, 0, 0, 8, 1, 0);
    @(negedge clk);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step();
    drive(1, 0, 1, 0, 0, 8, 1, 0);
    @(negedge clk);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 8, 1, 13, 1, 0);
      @(negedge clk);
      n_cmp++;
      if (ctrl_a !== exp_ctrl(1'b1) || ctrl_b !== exp_ctrl(1'b0)) begin
        n_bad++; $display("[TB] FAIL waw_ctrl i=%0d got=%b/%b want=%b/%b", i, ctrl_a, ctrl_b, exp_ctrl(1'b1), exp_ctrl(1'b0));
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (stall_cnt_a !== WA'(2) || stall_cnt_b !== WB'(3)) begin
      n_bad++; $display("[TB] FAIL waw_stall_cnt got=%0d/%0d want=2/3", stall_cnt_a, stall_cnt_b);
    end
  endtask

  task automatic test_flush_priority();
    apply_reset();
    drive(1, 0, 1, 0, 0, 9, 1, 0);
    @(negedge clk);
    step();
    drive(1, 9, 1, 0, 0, 10, 1, 1);
    @(negedge clk);
    n_cmp++;
    if (ctrl_a !== 4'b0011 || ctrl_b !== 4'b0011) begin
      n_bad++; $display("[TB] FAIL flush_ctrl got=%b/%b want=0011/0011", ctrl_a, ctrl_b);
    end
    step();
    drive(1, 10, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (flush_cnt_a !== WA'(1) || stall_cnt_a !== '0 || flush_cnt_b !== WB'(1) || stall_cnt_b !== '0) begin
      n_bad++; $display("[TB] FAIL flush_cnts got=%0d,%0d/%0d,%0d want=1,0/1,0", flush_cnt_a, stall_cnt_a, flush_cnt_b, stall_cnt_b);
    end
    n_cmp++;
    if (pc_hold_a !== 1'b0 || pc_hold_b !== 1'b0) begin
      n_bad++; $display("[TB] FAIL flushed_no_load got=%b/%b want=0/0", pc_hold_a, pc_hold_b);
    end
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1, 0, 1, 0, 0, 4, 1, 0);
    @(negedge clk);
    step();
    drive(1, 4, 1, 0, 0, 14, 1, 0);
    @(negedge clk);
    step();
    @(negedge clk);
    n_cmp++;
    if (pc_hold_a !== 1'b1 || pc_hold_b !== 1'b1 || stall_cnt_a !== WA'(1)) begin
      n_bad++; $display("[TB] FAIL mid_pre_stall got=%b/%b cnt=%0d want=1/1 cnt=1", pc_hold_a, pc_hold_b, stall_cnt_a);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ctrl_a !== 4'b0000 || ctrl_b !== 4'b0000) begin
      n_bad++; $display("[TB] FAIL mid_reset_ctrl got=%b/%b want=0000/0000", ctrl_a, ctrl_b);
    end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (stall_cnt_a !== '0 || stall_cnt_b !== '0 || pc_hold_a !== 1'b0 || pc_hold_b !== 1'b0) begin
      n_bad++; $display("[TB] FAIL mid_release got=%0d/%0d hold=%b/%b want=0/0 hold=0/0", stall_cnt_a, stall_cnt_b, pc_hold_a, pc_hold_b);
    end
    step();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      drive(logic'($urandom_range(7) != 0), 5'($urandom_range(7)), logic'($urandom_range(1)),
            5'($urandom_range(7)), logic'($urandom_range(1)), 5'($urandom_range(7)),
            logic'($urandom_range(3) != 0), logic'($urandom_range(9) == 0));
      @(negedge clk);
      n_cmp++;
      if (ctrl_a !== exp_ctrl(1'b1) || ctrl_b !== exp_ctrl(1'b0)) begin
        n_bad++; $display("[TB] FAIL rand_ctrl cyc=%0d got=%b/%b want=%b/%b", cyc, ctrl_a, ctrl_b, exp_ctrl(1'b1), exp_ctrl(1'b0));
      end
      n_cmp++;
      if (stall_cnt_a !== WA'(sc_a) || flush_cnt_a !== WA'(fc_a) || stall_cnt_b !== WB'(sc_b) || flush_cnt_b !== WB'(fc_b)) begin
        n_bad++; $display("[TB] FAIL rand_cnts cyc=%0d got=%0d,%0d/%0d,%0d want=%0d,%0d/%0d,%0d",
                          cyc, stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b, sc_a, fc_a, sc_b, fc_b);
      end
      step();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    test_reset();
    test_independent();
    test_raw();
    test_x0_unused();
    test_waw();
    test_flush_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
